// File: rtl/dm_stage.sv
// dm_stage: data-memory stage of the load/store path.
// Word-organised memory with word stores, sized loads (LW/LH/LHU/LB/LBU),
// write-first forwarding on a same-edge store/load collision and a tagged
// load-result FIFO toward writeback. Load latency is one cycle: read at the
// accept edge, extend/check and push at the following edge.
module dm_stage #(
   parameter int ADDR_W     = 10,
   parameter int OUTQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_tag,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_instr,
   input  logic        st_we,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_tag,
   output logic [31:0] res_data,
   output logic        res_misalign,
   output logic        st_misalign
);

   localparam int PTR_W = $clog2(OUTQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 65;   // {misalign, data, tag}

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;

   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_BYTE = 2'd2;

   logic [31:0]       mem [0:(2**ADDR_W)-1];

   logic [ADDR_W-1:0] ld_idx;
   logic [ADDR_W-1:0] st_idx;
   logic              st_ok;
   logic              ld_acc;

   logic [1:0]        dec_size;
   logic              dec_signed;

   // in-flight stage
   logic              inflight_reg;
   logic [31:0]       rd_word_reg;
   logic              fwd_hit_reg;
   logic [31:0]       fwd_data_reg;
   logic [31:0]       infl_tag_reg;
   logic [1:0]        infl_size_reg;
   logic              infl_signed_reg;
   logic [1:0]        infl_off_reg;

   // completion path
   logic [31:0]       cpl_word;
   logic [31:0]       cpl_shift;
   logic [31:0]       cpl_data;
   logic              cpl_mis;
   logic [ENT_W-1:0]  cpl_entry;

   // result queue
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_W:0]    occupancy;
   logic              push;
   logic              pop;
   logic [OUTQ_DEPTH*ENT_W-1:0] q_flat;
   logic [ENT_W-1:0]  head;

   logic              st_misalign_reg;
   logic              unused_bits;

   assign ld_idx = ld_addr[ADDR_W+1:2];
   assign st_idx = st_addr[ADDR_W+1:2];
   assign st_ok  = st_we && (st_addr[1:0] == 2'b00);

   // Readiness depends only on registered state, never on res_ready.
   assign occupancy = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
   assign ld_ready  = occupancy < (CNT_W+1)'(OUTQ_DEPTH);
   assign ld_acc    = ld_valid && ld_ready;

   // Opcode decode: unknown opcodes fall back to a word load.
   always_comb begin
      dec_size   = SZ_WORD;
      dec_signed = 1'b0;
      case (ld_instr[31:26])
         OP_LH:   begin dec_size = SZ_HALF; dec_signed = 1'b1; end
         OP_LHU:  begin dec_size = SZ_HALF; dec_signed = 1'b0; end
         OP_LB:   begin dec_size = SZ_BYTE; dec_signed = 1'b1; end
         OP_LBU:  begin dec_size = SZ_BYTE; dec_signed = 1'b0; end
         default: begin dec_size = SZ_WORD; dec_signed = 1'b0; end
      endcase
   end

   // Aligned word store; nothing is written while reset is asserted.
   always_ff @(posedge clk) begin
      if (rst_n && st_ok)
         mem[st_idx] <= st_data;
   end

   // Registered memory read at the load accept edge (old data).
   always_ff @(posedge clk) begin
      if (ld_acc)
         rd_word_reg <= mem[ld_idx];
   end

   // Capture the load's side information and any same-edge store hit.
   always_ff @(posedge clk) begin
      if (ld_acc) begin
         fwd_hit_reg     <= st_ok && (st_idx == ld_idx);
         fwd_data_reg    <= st_data;
         infl_tag_reg    <= ld_tag;
         infl_size_reg   <= dec_size;
         infl_signed_reg <= dec_signed;
         infl_off_reg    <= ld_addr[1:0];
      end
   end

   // In-flight valid flag and misaligned-store pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight_reg    <= 1'b0;
         st_misalign_reg <= 1'b0;
      end else begin
         inflight_reg    <= ld_acc;
         st_misalign_reg <= st_we && (st_addr[1:0] != 2'b00);
      end
   end

   // Forwarding mux, byte/half select, extension and alignment check.
   always_comb begin
      cpl_word  = fwd_hit_reg ? fwd_data_reg : rd_word_reg;
      cpl_shift = cpl_word >> {infl_off_reg, 3'b000};
      cpl_data  = cpl_word;
      cpl_mis   = 1'b0;
      case (infl_size_reg)
         SZ_HALF: begin
            cpl_mis  = infl_off_reg[0];
            cpl_data = {{16{infl_signed_reg & cpl_shift[15]}}, cpl_shift[15:0]};
         end
         SZ_BYTE: begin
            cpl_data = {{24{infl_signed_reg & cpl_shift[7]}}, cpl_shift[7:0]};
         end
         default: begin
            cpl_mis  = (infl_off_reg != 2'b00);
            cpl_data = cpl_word;
         end
      endcase
      if (cpl_mis)
         cpl_data = 32'h0;
      cpl_entry = {cpl_mis, cpl_data, infl_tag_reg};
   end

   assign push = inflight_reg;
   assign pop  = res_valid && res_ready;

   // Queue entry storage, one register per slot.
   generate
      for (genvar gi = 0; gi < OUTQ_DEPTH; gi++) begin : gen_slot
         logic [ENT_W-1:0] entry_reg;
         // Load a slot when the write pointer points at it.
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PTR_W'(gi)))
               entry_reg <= cpl_entry;
         end
         assign q_flat[gi*ENT_W +: ENT_W] = entry_reg;
      end
   endgenerate

   // Head-of-queue select.
   always_comb begin
      head = '0;
      for (int i = 0; i < OUTQ_DEPTH; i++) begin
         if (rd_ptr_reg == PTR_W'(i))
            head = q_flat[i*ENT_W +: ENT_W];
      end
   end

   // Occupancy after this edge's push/pop.
   always_comb begin
      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + 1'b1;
      else if (!push && pop)
         count_next = count_reg - 1'b1;
   end

   // Queue pointers and count; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         count_reg <= count_next;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   assign res_valid    = (count_reg != '0);
   assign res_tag      = res_valid ? head[31:0]  : 32'h0;
   assign res_data     = res_valid ? head[63:32] : 32'h0;
   assign res_misalign = res_valid ? head[64]    : 1'b0;
   assign st_misalign  = st_misalign_reg;

   // Address bits above the word index alias and are intentionally ignored.
   assign unused_bits = ^{ld_addr[31:ADDR_W+2], st_addr[31:ADDR_W+2], ld_instr[25:0]};

endmodule

// File: tb/tb_dm_stage.sv
// tb_dm_stage: directed and randomized checks of dm_stage against a
// transaction-level model (word array + expected-result queue).
module tb_dm_stage;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_tag;
   logic [31:0] ld_addr;
   logic [31:0] ld_instr;
   logic        st_we;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_tag;
   logic [31:0] res_data;
   logic        res_misalign;
   logic        st_misalign;

   dm_stage #(.ADDR_W(10), .OUTQ_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_tag(ld_tag),
      .ld_addr(ld_addr), .ld_instr(ld_instr),
      .st_we(st_we), .st_addr(st_addr), .st_data(st_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
      .res_data(res_data), .res_misalign(res_misalign), .st_misalign(st_misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] tag;
      logic [31:0] data;
      logic        mis;
   } res_t;

   logic [31:0] mem_m [0:1023];
   res_t        q_m [$];
   res_t        pend_m;
   bit          pend_v;
   bit          stmis_m;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected result of a load straight from the opcode/size rules.
   function automatic res_t make_result(input logic [31:0] tag, input logic [31:0] instr,
                                        input logic [31:0] addr, input logic [31:0] word);
      res_t r;
      logic [31:0] sh;
      r.tag  = tag;
      r.mis  = 1'b0;
      case (instr[31:26])
         6'h20: begin sh = word >> (8 * addr[1:0]); r.data = {{24{sh[7]}}, sh[7:0]}; end
         6'h24: begin sh = word >> (8 * addr[1:0]); r.data = {24'h0, sh[7:0]}; end
         6'h21: begin sh = word >> (16 * addr[1]); r.data = {{16{sh[15]}}, sh[15:0]}; r.mis = addr[0]; end
         6'h25: begin sh = word >> (16 * addr[1]); r.data = {16'h0, sh[15:0]}; r.mis = addr[0]; end
         default: begin r.data = word; r.mis = (addr[1:0] != 2'b00); end
      endcase
      if (r.mis) r.data = 32'h0;
      return r;
   endfunction

   // One clock edge: advance the model with the driven inputs, then compare.
   task automatic step();
      bit acc;
      bit pop;
      @(posedge clk);
      if (!rst_n) begin
         q_m.delete();
         pend_v  = 0;
         stmis_m = 0;
      end else begin
         acc = ld_valid && ((q_m.size() + int'(pend_v)) < DEPTH);
         pop = (q_m.size() > 0) && res_ready;
         if (pop) begin
            $display("pop tag=%0d data=%h mis=%0d", q_m[0].tag, q_m[0].data, q_m[0].mis);
            q_m.delete(0);
         end
         if (pend_v) q_m.push_back(pend_m);
         pend_v = acc;
         if (st_we && st_addr[1:0] == 2'b00) mem_m[st_addr[11:2]] = st_data;
         stmis_m = st_we && (st_addr[1:0] != 2'b00);
         if (acc) pend_m = make_result(ld_tag, ld_instr, ld_addr, mem_m[ld_addr[11:2]]);
      end
      #1;
      check("res_valid", res_valid, (q_m.size() > 0));
      if (q_m.size() > 0) begin
         check("res_tag", res_tag, q_m[0].tag);
         check("res_data", res_data, q_m[0].data);
         check("res_misalign", res_misalign, q_m[0].mis);
      end else begin
         check("res_tag_idle", res_tag, 32'h0);
         check("res_data_idle", res_data, 32'h0);
         check("res_mis_idle", res_misalign, 1'b0);
      end
      check("ld_ready", ld_ready, ((q_m.size() + int'(pend_v)) < DEPTH));
      check("st_misalign", st_misalign, stmis_m);
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      st_we = 1; st_addr = addr; st_data = data;
      step();
      st_we = 0;
   endtask

   // Issue one load with an empty queue and check its result one cycle later.
   task automatic load_check(input string name, input logic [31:0] tag, input logic [5:0] op,
                             input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_mis);
      ld_valid = 1; ld_tag = tag; ld_instr = {op, 26'h0}; ld_addr = addr;
      step();
      ld_valid = 0;
      step();
      check({name, "_valid"}, res_valid, 1'b1);
      check({name, "_tag"}, res_tag, tag);
      check({name, "_data"}, res_data, exp_data);
      check({name, "_mis"}, res_misalign, exp_mis);
   endtask

   initial begin
      int acc_cnt;
      logic [5:0] ops [6];
      ops[0] = 6'h23; ops[1] = 6'h21; ops[2] = 6'h25; ops[3] = 6'h20; ops[4] = 6'h24; ops[5] = 6'h3f;

      rst_n = 0; ld_valid = 0; ld_tag = 0; ld_addr = 0; ld_instr = 0;
      st_we = 0; st_addr = 0; st_data = 0; res_ready = 1;
      for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
      step(); step();
      rst_n = 1;
      check("rst_valid", res_valid, 1'b0);
      check("rst_ready", ld_ready, 1'b1);

      // give every word used later a known value
      for (int i = 0; i < 32; i++) store(i * 4, $urandom);

      // basic store then word load
      store(32'h10, 32'hDEADBEEF);
      load_check("lw10", 7, 6'h23, 32'h10, 32'hDEADBEEF, 1'b0);

      // sized loads
      store(32'h20, 32'h80FF7F01);
      load_check("lb23",  11, 6'h20, 32'h23, 32'hFFFFFF80, 1'b0);
      load_check("lbu23", 12, 6'h24, 32'h23, 32'h00000080, 1'b0);
      load_check("lh22",  13, 6'h21, 32'h22, 32'hFFFF80FF, 1'b0);
      load_check("lhu20", 14, 6'h25, 32'h20, 32'h00007F01, 1'b0);
      load_check("lb21",  15, 6'h20, 32'h21, 32'h0000007F, 1'b0);
      load_check("lhmis", 16, 6'h25, 32'h21, 32'h0, 1'b1);

      // forwarding: earlier load sees old data, same-edge load sees new
      store(32'h40, 32'h11111111);
      res_ready = 0;
      ld_valid = 1; ld_tag = 20; ld_instr = {6'h23, 26'h0}; ld_addr = 32'h40;
      step();
      ld_tag = 21; st_we = 1; st_addr = 32'h40; st_data = 32'h22222222;
      step();
      ld_valid = 0; st_we = 0;
      step();
      check("fwd_old_tag", res_tag, 32'd20);
      check("fwd_old_data", res_data, 32'h11111111);
      res_ready = 1;
      step();
      check("fwd_new_tag", res_tag, 32'd21);
      check("fwd_new_data", res_data, 32'h22222222);
      step();

      // misalignment
      load_check("lwmis", 9, 6'h23, 32'h42, 32'h0, 1'b1);
      store(32'h41, 32'h0BAD0BAD);
      check("st_mis_pulse", st_misalign, 1'b1);
      step();
      check("st_mis_clear", st_misalign, 1'b0);
      load_check("lw40", 30, 6'h23, 32'h40, 32'h22222222, 1'b0);
      step();

      // backpressure: six attempts with writeback stalled
      res_ready = 0; acc_cnt = 0;
      ld_instr = {6'h23, 26'h0}; ld_addr = 32'h10; ld_tag = 100;
      for (int i = 0; i < 6; i++) begin
         ld_valid = 1;
         if (ld_ready) begin
            acc_cnt++;
            step();
            ld_tag = ld_tag + 1;
         end else begin
            step();
         end
      end
      ld_valid = 0;
      check("bp_accepted", acc_cnt, 4);
      check("bp_ready_low", ld_ready, 1'b0);
      res_ready = 1;
      for (int k = 0; k < 4; k++) begin
         check("drain_tag", res_tag, 32'(100 + k));
         step();
      end
      check("drain_empty", res_valid, 1'b0);
      check("drain_ready", ld_ready, 1'b1);

      // full throughput with writeback always ready
      for (int i = 0; i < 8; i++) begin
         ld_valid = 1; ld_tag = 200 + i; ld_addr = 32'h20; ld_instr = {6'h24, 26'h0};
         check("tput_ready", ld_ready, 1'b1);
         step();
      end
      ld_valid = 0;
      step(); step();

      // reset with three queued results, one in flight and a store pending
      res_ready = 0;
      ld_instr = {6'h23, 26'h0}; ld_addr = 32'h40;
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1; ld_tag = 300 + i;
         step();
      end
      ld_valid = 0;
      check("pre_rst_ready", ld_ready, 1'b0);
      rst_n = 0; st_we = 1; st_addr = 32'h10; st_data = 32'h0BADF00D;
      step();
      rst_n = 1; st_we = 0;
      check("mid_rst_valid", res_valid, 1'b0);
      check("mid_rst_ready", ld_ready, 1'b1);
      res_ready = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("no_stale", res_valid, 1'b0);
      end
      load_check("lw_after_rst", 40, 6'h23, 32'h10, 32'hDEADBEEF, 1'b0);
      step();

      // randomized traffic with aliasing upper address bits
      for (int c = 0; c < 400; c++) begin
         ld_valid  = ($urandom_range(0, 1) == 1);
         ld_tag    = 1000 + c;
         ld_instr  = {ops[$urandom_range(0, 5)], 26'($urandom)};
         ld_addr   = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
         st_we     = ($urandom_range(0, 2) == 0);
         st_addr   = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 31)) << 2)
                     | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
         st_data   = $urandom;
         res_ready = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 99) != 0);
         step();
      end
      rst_n = 1; ld_valid = 0; st_we = 0; res_ready = 1;
      for (int i = 0; i < 8; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
